// File: rtl/riscv_pkg.sv
// Shared core-level constants and enumerations used by the adder-sharing block.
// XLEN sets the default datapath width; req_id_e names the fixed requester slots.
package riscv_pkg;

    localparam int XLEN = 32;

    // Requester slots of the shared address adder inside the core.
    typedef enum logic [1:0] {
        REQ_PC  = 2'd0,
        REQ_BR  = 2'd1,
        REQ_ALU = 2'd2
    } req_id_e;

    // Occupancy of the one-entry result register.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// scanning upward from ptr_i with wrap-around, or nothing when en_i is low.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic             found;
    int               idx;
    logic [PTR_W-1:0] idx_w;

    // NOTE: every signal driven here gets a default before the loop, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = PTR_W'(idx);
            if (en_i && !found && req_i[idx_w]) begin
                grant_o[idx_w] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One registered WIDTH-bit adder shared round-robin between NUM_REQ requesters,
// with a one-entry result register tagged by the winning requester index.
module adder_share_arbiter
    import riscv_pkg::*;
#(
    parameter int WIDTH   = XLEN,
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_sum,
    output logic                     resp_carry
);

    out_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic             can_accept;
    logic             arb_en;
    logic [NUM_REQ-1:0] grant;
    logic             fire;
    logic [ID_W-1:0]  win_idx;
    logic [WIDTH-1:0] win_a, win_b;
    logic [WIDTH:0]   add_full;

    assign can_accept = (state_q == OUT_EMPTY) || resp_ready;

    // Reset is folded into the enable so nothing is offered while rst_n is low,
    // even though the empty register would otherwise be able to accept.
    assign arb_en = can_accept && rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign fire      = |grant;

    // One-hot grant to index plus an AND-OR operand mux.
    always_comb begin
        win_idx = '0;
        win_a   = '0;
        win_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx = ID_W'(i);
                win_a   = req_a[i*WIDTH +: WIDTH];
                win_b   = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign add_full = {1'b0, win_a} + {1'b0, win_b};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A same-cycle drain and refill keeps the register FULL with no bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (fire) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (resp_ready && !fire) begin
                    state_d = OUT_EMPTY;
                end
            end
        endcase
    end

    assign resp_valid = (state_q == OUT_FULL);

    // Payload and pointer move only on a transfer; a plain drain leaves them as is.
    always_comb begin
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (fire) begin
            id_d    = win_idx;
            sum_d   = add_full[WIDTH-1:0];
            carry_d = add_full[WIDTH];
            ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign resp_id    = id_q;
    assign resp_sum   = sum_q;
    assign resp_carry = carry_q;

    grant_onehot_a : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(req_ready)
    );

    stall_hold_a : assert property (
        @(posedge clk) disable iff (!rst_n)
        (resp_valid && !resp_ready) |=>
            (resp_valid && $stable(resp_sum) && $stable(resp_id) && $stable(resp_carry))
    );

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one registered 32-bit adder between NUM_REQ requesters, e.g. PC+4, branch-target and ALU address generation in the RISC-V core.
- Round-robin arbitration with a valid/ready handshake on each request port.
- One-entry result register with valid/ready backpressure toward the consumer.
- Result is tagged with the winning requester ID.

Parameters:
- WIDTH, 32, operand and sum width.
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID tag.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset: asynchronous assert, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A; slice i = [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same slicing as req_a.
- resp_valid  output  1  result register holds a valid sum.
- resp_ready  input  1  consumer accepts the result.
- resp_id  output  ID_W  index of the requester that produced the result.
- resp_sum  output  WIDTH  (A+B) mod 2^WIDTH.
- resp_carry  output  1  carry-out of A+B.

Behaviour:
- Reset (rst_n=0, async) clears:
  - resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0.
  - Priority pointer ptr=0.
- While in reset, req_ready=0.
- Output state is a one-bit full flag, equal to resp_valid:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
  - can_accept = !resp_valid || resp_ready.
- Grant (combinational):
  - If can_accept, grant the first asserted req_valid scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - req_ready = one-hot grant. No grant when can_accept=0 or no request is valid.
  - req_ready must not depend on req_a/req_b.
- Transfer on requester i occurs when req_valid[i] && req_ready[i]. At that edge:
  - {resp_carry, resp_sum} <= req_a[i] + req_b[i], computed at WIDTH+1 bits.
  - resp_id <= i; resp_valid <= 1.
  - ptr <= (i+1) mod NUM_REQ.
- Latency: result is visible one cycle after the accepting edge.
- Throughput: one sum per cycle while resp_ready=1.
- Drain without a new grant (resp_valid && resp_ready, no transfer): resp_valid <= 0. resp_sum, resp_carry and resp_id hold their last values.
- Simultaneous drain and new transfer in the same cycle: the new result replaces the old one, resp_valid stays 1, no bubble.
- While FULL and resp_ready=0:
  - Every output holds stable.
  - req_ready = 0.
  - ptr is unchanged.
- ptr changes only on a transfer, never on an idle cycle.
- Fairness: a continuously asserted request is granted within NUM_REQ transfers.
- Requesters may not drop req_valid before handshake. The block does not need to detect this; behaviour is still well-defined because grant is re-evaluated every cycle.
- Reset mid-operation clears the pending result immediately. The in-flight result is lost and is not replayed.
- Overflow: the sum wraps modulo 2^WIDTH and the lost bit appears on resp_carry. No saturation, no signed flag.

Decomposition:
- Shared package (riscv_pkg): XLEN=32 constant used as the WIDTH default; the requester ID enumeration REQ_PC=0, REQ_BR=1, REQ_ALU=2.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req vector, ptr, enable.
  - Output: one-hot grant.
  - Purely combinational.
- The adder is an inline WIDTH+1-bit add in the parent; no separate instance.

Test Plan:
- Reset: hold rst_n=0 with req_valid=3'b111 -> req_ready=0, resp_valid=0, resp_sum=0. After release, the first grant goes to requester 0.
- Single request: req 1 with A=0x0000_1000, B=0x0000_0004, resp_ready=1 -> next cycle resp_valid=1, resp_id=1, resp_sum=0x0000_1004, resp_carry=0.
- Round-robin: all three valid for 6 cycles, resp_ready=1 -> grant order 0,1,2,0,1,2; resp_id follows one cycle later.
- Backpressure: result pending, resp_ready=0 for 3 cycles with req 2 valid -> req_ready=0 and outputs stable for those cycles. On resp_ready=1: same-cycle grant to req 2, resp_valid stays 1, new sum appears next cycle.
- Overflow: A=0xFFFF_FFFF, B=0x0000_0002 -> resp_sum=0x0000_0001, resp_carry=1.
- Async reset mid-stream: assert rst_n=0 between clock edges while FULL -> resp_valid drops to 0 immediately (no edge needed), ptr returns to 0.
